div32_seq: RTL



---
 rtl/div32_seq.sv | 94 +++++++++
 1 files changed

// File: rtl/div32_seq.sv
// Sequential 32-bit unsigned restoring divider: one quotient bit per clock through a
// single 33-bit subtractor, start/done handshake, divide-by-zero flagged without iterating.
module div32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] r;
    logic [31:0] q;
    logic [31:0] dvs;
    logic [4:0]  cnt;

    logic [32:0] t;
    logic [32:0] diff;
    logic [31:0] r_next;
    logic [31:0] q_next;

    // The partial remainder never exceeds the divisor, so 32 stored bits suffice;
    // the shifted-in bit t[32] still feeds the full 33-bit subtract.
    always_comb begin
        t      = {r, q[31]};
        diff   = t - {1'b0, dvs};
        r_next = diff[32] ? t[31:0] : diff[31:0];
        q_next = {q[30:0], ~diff[32]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            cnt       <= '0;
            r         <= '0;
            q         <= '0;
            dvs       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor == 32'd0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            r     <= '0;
                            q     <= dividend;
                            dvs   <= divisor;
                            cnt   <= '0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
